// File: rtl/histogram_cdf_reader.sv
// Histogram equalizer stage 2: streams tagged bin counts out of m2, accumulates a
// saturating CDF and writes one tagged CDF entry per bin into m3.
module histogram_cdf_reader #(
    parameter int          NUM_BINS = 256,
    parameter logic [15:0] TAG      = 16'hAAAA,
    parameter int          DATA_W   = 128,
    parameter int          ADDR_W   = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] m2ReadVal,
    output logic [ADDR_W-1:0] m2ReadAddr,
    output logic [ADDR_W-1:0] m3WriteAddr,
    output logic [DATA_W-1:0] m3WriteVal,
    output logic              m3WE,
    output logic              busy,
    output logic              done,
    output logic [15:0]       cdf_min,
    output logic [15:0]       total,
    output logic              empty
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BINS - 1);

    state_t            state, state_nxt;
    logic              accept;
    logic              finish;
    logic [1:0]        vld_pipe;   // [0]: m2 data for rd_addr arrives, [1]: m3 write presented
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       acc;
    logic              min_found;
    logic [15:0]       count;
    logic [16:0]       sum;
    logic [15:0]       cdf_nxt;
    logic              unused_hi;

    assign unused_hi = ^m2ReadVal[DATA_W-1:32];

    // Untagged words are bins the counting stage never touched.
    assign count   = (m2ReadVal[31:16] == TAG) ? m2ReadVal[15:0] : 16'h0;
    assign sum     = {1'b0, acc} + {1'b0, count};
    assign cdf_nxt = sum[16] ? 16'hFFFF : sum[15:0];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (m2ReadAddr == LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (m3WE && m3WriteAddr == LAST) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m3WE = vld_pipe[1];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m2ReadAddr  <= '0;
            m3WriteAddr <= '0;
            m3WriteVal  <= '0;
            vld_pipe    <= '0;
            rd_addr     <= '0;
            acc         <= '0;
            min_found   <= 1'b0;
            cdf_min     <= '0;
            total       <= '0;
            empty       <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], state == ISSUE};
            rd_addr  <= m2ReadAddr;
            if (accept) begin
                m2ReadAddr <= '0;
                acc        <= '0;
                min_found  <= 1'b0;
                cdf_min    <= '0;
                total      <= '0;
                empty      <= 1'b0;
            end else begin
                if (state == ISSUE && m2ReadAddr != LAST)
                    m2ReadAddr <= m2ReadAddr + 1'b1;
                if (vld_pipe[0]) begin
                    acc         <= cdf_nxt;
                    m3WriteAddr <= rd_addr;
                    m3WriteVal  <= {{(DATA_W-32){1'b0}}, TAG, cdf_nxt};
                    if (!min_found && count != 16'h0) begin
                        min_found <= 1'b1;
                        cdf_min   <= cdf_nxt;
                    end
                end
                if (finish) begin
                    total <= acc;
                    empty <= !min_found;
                end
            end
        end
    end
endmodule

// File: tb/tb_histogram_cdf_reader.sv
// Directed bench for histogram_cdf_reader: registered m2 model, m3 capture, hand-computed CDFs.
module tb_histogram_cdf_reader;
    logic         clock = 0;
    logic         rst_n = 0;
    logic         start = 0;
    logic [127:0] m2ReadVal;
    logic [15:0]  m2ReadAddr, m3WriteAddr;
    logic [127:0] m3WriteVal;
    logic         m3WE, busy, done, empty;
    logic [15:0]  cdf_min, total;

    logic [127:0] m2 [256];
    logic [127:0] m3 [256];
    int vecs = 0, errs = 0;
    int done_cyc, wr_cnt, wr_bad, addr1;

    histogram_cdf_reader dut (
        .clock(clock), .rst_n(rst_n), .start(start), .m2ReadVal(m2ReadVal),
        .m2ReadAddr(m2ReadAddr), .m3WriteAddr(m3WriteAddr), .m3WriteVal(m3WriteVal),
        .m3WE(m3WE), .busy(busy), .done(done), .cdf_min(cdf_min), .total(total), .empty(empty)
    );

    always #5 clock = ~clock;

    always @(posedge clock) m2ReadVal <= m2[m2ReadAddr[7:0]];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int lo, input int hi, input logic [15:0] cdf);
        logic [127:0] exp;
        int bad;
        exp = {96'h0, 16'hAAAA, cdf};
        bad = 0;
        for (int i = lo; i <= hi; i++) if (m3[i] !== exp) bad++;
        chk(tag, 128'(bad), 128'd0);
    endtask

    task automatic clear_m2();
        for (int i = 0; i < 256; i++) m2[i] = '0;
    endtask

    // Cycle n is the period following edge n-1, with the accepting edge E0 being edge 0.
    task automatic run_pass(input int mid, input int abort_at);
        int n;
        for (int i = 0; i < 256; i++) m3[i] = '1;
        done_cyc = 0; wr_cnt = 0; wr_bad = 0; addr1 = -1;
        @(negedge clock) start = 1;
        @(posedge clock);
        #1 start = 0;
        n = 1;
        while (n < 400 && done_cyc == 0) begin
            @(negedge clock);
            start = (n == mid);
            if (n == 1) addr1 = int'(m2ReadAddr);
            if (m3WE) begin
                wr_cnt++;
                if (int'(m3WriteAddr) != n - 3 || m3WriteVal[127:32] !== 96'h0) wr_bad++;
                m3[m3WriteAddr[7:0]] = m3WriteVal;
            end
            if (done && done_cyc == 0) done_cyc = n;
            if (n == abort_at) break;
            n++;
        end
        start = 0;
    endtask

    task automatic chk_pass(input string tag, input logic [15:0] mn, input logic [15:0] tot, input logic emp);
        chk({tag, "_addr1"}, 128'(addr1), 128'd0);
        chk({tag, "_done_cyc"}, 128'(done_cyc), 128'd259);
        chk({tag, "_wr_cnt"}, 128'(wr_cnt), 128'd256);
        chk({tag, "_wr_timing"}, 128'(wr_bad), 128'd0);
        chk({tag, "_status"}, {busy, done, m3WE}, 3'b010);
        chk({tag, "_rd_hold"}, m2ReadAddr, 16'd255);
        chk({tag, "_cdf_min"}, cdf_min, mn);
        chk({tag, "_total"}, total, tot);
        chk({tag, "_empty"}, empty, emp);
    endtask

    initial begin
        int we_seen;
        clear_m2();
        #1;
        chk("reset_outputs", {m2ReadAddr, m3WriteAddr, m3WriteVal, m3WE, busy, done, cdf_min, total, empty}, '0);
        #20 rst_n = 1;

        // Two isolated counts.
        m2[3] = {96'h0, 32'hAAAA_0005};
        m2[200] = {96'h0, 32'hAAAA_000A};
        run_pass(0, 0);
        chk_pass("p1", 16'h5, 16'hF, 1'b0);
        chk_range("p1_b0_2", 0, 2, 16'h0);
        chk_range("p1_b3_199", 3, 199, 16'h5);
        chk_range("p1_b200_255", 200, 255, 16'hF);

        // Back-to-back from DONE with an empty histogram.
        repeat (3) @(negedge clock);
        clear_m2();
        run_pass(0, 0);
        chk_pass("p2", 16'h0, 16'h0, 1'b1);
        chk_range("p2_all", 0, 255, 16'h0);

        // Saturation.
        clear_m2();
        m2[0] = {96'h0, 32'hAAAA_F000};
        m2[1] = {96'h0, 32'hAAAA_F000};
        run_pass(0, 0);
        chk_pass("p3", 16'hF000, 16'hFFFF, 1'b0);
        chk_range("p3_b0", 0, 0, 16'hF000);
        chk_range("p3_b1_255", 1, 255, 16'hFFFF);

        // Foreign tag ignored, plus a start pulse mid-pass that must have no effect.
        clear_m2();
        m2[10] = {96'h0, 32'hAAAA_0003};
        m2[20] = {96'h0, 32'h1234_0007};
        m2[30] = {96'h0, 32'hAAAA_0004};
        m2[255] = {96'h0, 32'h0000_FFFF};
        run_pass(100, 0);
        chk_pass("p4", 16'h3, 16'h7, 1'b0);
        chk_range("p4_b0_9", 0, 9, 16'h0);
        chk_range("p4_b10_29", 10, 29, 16'h3);
        chk_range("p4_b30_255", 30, 255, 16'h7);

        // Reset mid-pass at cycle 150.
        run_pass(0, 150);
        chk("p5_busy_before_reset", busy, 1'b1);
        rst_n = 0;
        #1;
        chk("p5_reset_outputs", {m2ReadAddr, m3WriteAddr, m3WriteVal, m3WE, busy, done, cdf_min, total, empty}, '0);
        we_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (i == 2) rst_n = 1;
            if (m3WE) we_seen++;
        end
        chk("p5_no_writes_after_reset", 128'(we_seen), 128'd0);
        chk("p5_idle_after_reset", {busy, done}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/histogram_cdf_reader.md
Name: histogram_cdf_reader

Overview:
- Second stage of the histogram equalizer.
- Reads the 256 tagged bin counts that the counting stage left in scratchpad m2, forms a running cumulative distribution (CDF) and writes one tagged CDF entry per bin into scratchpad m3.
- Reports the minimum non-zero CDF value and the total pixel count for the downstream mapping/output stage that writes m4.

Parameters:
- NUM_BINS, 256: number of histogram bins; bin k is stored at m2/m3 address k.
- TAG, 16'hAAAA: valid marker held in bits [31:16] of every scratchpad entry.
- DATA_W, 128: scratchpad word width.
- ADDR_W, 16: scratchpad address width.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a pass when idle.
- m2ReadVal  in  DATA_W  m2 read data, valid one cycle after m2ReadAddr.
- m2ReadAddr  out  ADDR_W  m2 read address (registered).
- m3WriteAddr  out  ADDR_W  m3 write address (registered).
- m3WriteVal  out  DATA_W  m3 write data: {96'b0, TAG, cdf[15:0]}.
- m3WE  out  1  m3 write enable.
- busy  out  1  pass in progress.
- done  out  1  pass complete; held until next accepted start.
- cdf_min  out  16  CDF value of the first bin with a non-zero count.
- total  out  16  final CDF value (total pixels, saturated).
- empty  out  1  every bin had count 0.

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE. All outputs are 0: m2ReadAddr, m3WriteAddr, m3WriteVal, m3WE, busy, done, cdf_min, total, empty. The accumulator and pipeline valid bits are also cleared. Reset asserted mid-pass aborts the pass immediately; no further m3 writes occur.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE or DONE with start=1 at edge E0:
  - Enter ISSUE, busy=1, done=0.
  - Clear accumulator, cdf_min, total and the "min found" flag.
  - m2ReadAddr=0 in the cycle after E0.
- start while busy is ignored.
- ISSUE: m2ReadAddr increments by 1 per cycle. After issuing address NUM_BINS-1, go to DRAIN.
- Read pipeline, address k issued in cycle t:
  - m2ReadVal for bin k is sampled at the end of cycle t+1.
  - count_k = m2ReadVal[15:0] if m2ReadVal[31:16]==TAG, else 0. An untagged entry is an unvisited bin.
  - cdf_k = min(cdf_{k-1} + count_k, 16'hFFFF), with a 17-bit add then saturation; cdf_{-1}=0.
  - Cycle t+2: m3WE=1, m3WriteAddr=k, m3WriteVal={96'b0, TAG, cdf_k}.
- Write timing: for E0 = cycle 0, bin k is written in cycle k+3. This gives 256 consecutive write cycles, 3..258, with no gaps.
- cdf_min: latched on the first k with count_k != 0, value cdf_k (== count_k). Later bins do not change it.
- DRAIN: wait until the bin NUM_BINS-1 write has been presented.
- DONE:
  - Entered in cycle 259: busy=0, done=1, m3WE=0.
  - total=cdf_255. empty=1 iff no non-zero count was seen (cdf_min stays 0).
  - done, cdf_min, total and empty hold until the next accepted start or reset.
- m3WE is 0 in every cycle except the 256 write cycles. m2ReadAddr holds NUM_BINS-1 after issue completes, until the next start.
- start arriving in the same cycle as the DONE transition is ignored. start in DONE begins a new pass exactly as from IDLE.

Test Plan:
- m2 bin 3 = {AAAA,0005}, bin 200 = {AAAA,000A}, all other bins untagged, start at cycle 0:
  - m3 bins 0-2 written {AAAA,0000}; bins 3-199 {AAAA,0005}; bins 200-255 {AAAA,000F}.
  - cdf_min=5, total=15, empty=0.
  - done rises in cycle 259.
- All m2 bins untagged (zeros):
  - All 256 m3 entries = {AAAA,0000}.
  - cdf_min=0, total=0, empty=1, done=1.
- Bins 0 and 1 each {AAAA,F000}:
  - cdf_0=F000; cdf_1 and all later bins = FFFF (saturated); total=FFFF.
- A bin whose tag is not AAAA (e.g. {1234,0007}) is treated as count 0; the CDF does not change at that bin.
- start pulsed again at cycle 100 mid-pass: ignored, and the results match a clean pass. Then reset at cycle 150: all outputs 0 and m3WE stays 0 afterwards.
- Back-to-back passes: start in the DONE state re-clears accumulator, done and cdf_min. The second pass's results depend only on the second m2 contents.
